// File: rtl/window_feed_scheduler.sv
// Feeds one frame of raw pixels into the window fetcher: stamps col/row on each
// accepted pixel, then appends zero flush pixels so trailing edge windows drain.
module window_feed_scheduler #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned WINDOW_WIDTH  = 3,
  parameter int unsigned WINDOW_HEIGHT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [31:0] FLUSH_COUNT =
    32'((WINDOW_HEIGHT / 2) * IMAGE_WIDTH + WINDOW_WIDTH / 2);
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] col, row;
  logic [31:0] flush_cnt;
  logic        kill, accept, last_real, last_flush, emit;

  assign kill       = abort_i && (state != IDLE);
  assign accept     = valid_i && (state == STREAM);
  assign last_real  = accept && (col == LAST_COL) && (row == LAST_ROW);
  assign last_flush = (state == FLUSH) && (flush_cnt == FLUSH_COUNT - 32'd1);
  assign emit       = accept || (state == FLUSH);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start_i && !abort_i) state_next = STREAM;
      STREAM: begin
        if (abort_i)        state_next = IDLE;
        else if (last_real) state_next = (FLUSH_COUNT == 32'd0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (abort_i)         state_next = IDLE;
        else if (last_flush) state_next = DONE;
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The final pixel lands in the output registers as the FSM enters DONE,
  // so done_o decoded from state lines up with that last valid_o.
  always_comb begin
    ready_o = (state == STREAM);
    busy_o  = (state != IDLE);
    done_o  = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o    <= '0;
      col_o     <= '0;
      row_o     <= '0;
      valid_o   <= 1'b0;
      flush_o   <= 1'b0;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
    end else begin
      valid_o <= 1'b0;
      flush_o <= 1'b0;
      if (kill) begin
        col       <= '0;
        row       <= '0;
        flush_cnt <= '0;
      end else begin
        if (state == IDLE && start_i) begin
          col       <= '0;
          row       <= '0;
          flush_cnt <= '0;
        end
        if (emit) begin
          data_o  <= accept ? data_i : '0;
          col_o   <= col;
          row_o   <= row;
          valid_o <= 1'b1;
          flush_o <= (state == FLUSH);
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + 16'd1;
          end else begin
            col <= col + 16'd1;
          end
        end
        if (state == FLUSH) flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_feed_scheduler.sv
// Directed bench: a 4x3 frame through a 3x3-window scheduler (a) and a 1x1 one (b)
// sharing the same stimulus; outputs are logged at negedge and compared to tables.
module tb_window_feed_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, valid_i = 1'b0;
  logic [15:0] data_i = '0;

  logic        ready_a, valid_a, flush_a, busy_a, done_a;
  logic [15:0] data_a, col_a, row_a;
  logic        ready_b, valid_b, flush_b, busy_b, done_b;
  logic [15:0] data_b, col_b, row_b;

  always #5 clk = ~clk;

  window_feed_scheduler #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                          .WINDOW_WIDTH(3), .WINDOW_HEIGHT(3)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_a), .data_o(data_a),
    .col_o(col_a), .row_o(row_a), .valid_o(valid_a), .flush_o(flush_a),
    .busy_o(busy_a), .done_o(done_a));

  window_feed_scheduler #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                          .WINDOW_WIDTH(1), .WINDOW_HEIGHT(1)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_b), .data_o(data_b),
    .col_o(col_b), .row_o(row_b), .valid_o(valid_b), .flush_o(flush_b),
    .busy_o(busy_b), .done_o(done_b));

  typedef struct {
    logic [15:0] data, col, row;
    logic        flush, done;
    int          stamp;
  } obs_t;

  obs_t qa[$], qb[$];
  int   acc[$];
  int   cyc = 0;
  int   done_cnt_a = 0, done_cnt_b = 0, flush_cnt_b = 0;
  int   busy_after_a = -1;
  logic prev_done_a = 1'b0;
  int   n_vec = 0, n_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_a) qa.push_back('{data: data_a, col: col_a, row: row_a,
                                flush: flush_a, done: done_a, stamp: cyc});
    if (valid_b) qb.push_back('{data: data_b, col: col_b, row: row_b,
                                flush: flush_b, done: done_b, stamp: cyc});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (flush_b) flush_cnt_b++;
    if (prev_done_a) busy_after_a = int'(busy_a);
    prev_done_a = done_a;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feeds pixels k=0..11 (data=row*16+col); optional abort after N accepts and
  // optional stray start pulse at accept index start_at.
  task automatic run_frame(input bit toggle, input int abort_after, input int start_at,
                           input int tail);
    int k = 0, guard = 0;
    bit ph = 1'b1;
    acc.delete(); qa.delete(); qb.delete();
    done_cnt_a = 0; done_cnt_b = 0; flush_cnt_b = 0; busy_after_a = -1;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    while (k < 12 && guard < 100) begin
      valid_i = toggle ? ph : 1'b1;
      ph = ~ph;
      data_i = 16'((k / 4) * 16 + k % 4);
      if (start_at >= 0 && k == start_at) start_i = 1'b1;
      @(negedge clk);
      if (k == 3) check("busy_stream", 64'(busy_a), 64'd1);
      if (ready_a && valid_i) begin
        acc.push_back(cyc);
        k++;
      end
      @(posedge clk); #1 start_i = 1'b0;
      guard++;
      if (k == abort_after) begin
        abort_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 abort_i = 1'b0;
        break;
      end
    end
    valid_i = 1'b0;
    check("feed_timeout", 64'(guard >= 100), 64'd0);
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic verify_a(input string tag);
    check({tag, " n_out"}, 64'(qa.size()), 64'd17);
    check({tag, " n_acc"}, 64'(acc.size()), 64'd12);
    check({tag, " done_cnt"}, 64'(done_cnt_a), 64'd1);
    check({tag, " busy_after_done"}, 64'(busy_after_a), 64'd0);
    check({tag, " ready_end"}, 64'(ready_a), 64'd0);
    for (int i = 0; i < qa.size() && i < 17; i++) begin
      int c, r;
      logic [15:0] d;
      c = i % 4;
      r = i / 4;
      d = (i < 12) ? 16'(r * 16 + c) : 16'd0;
      check($sformatf("%s pix%0d", tag, i),
            {qa[i].data, qa[i].col, qa[i].row, qa[i].flush, qa[i].done},
            {d, 16'(c), 16'(r), (i >= 12), (i == 16)});
      if (i < 12 && i < acc.size())
        check($sformatf("%s lat%0d", tag, i), 64'(qa[i].stamp), 64'(acc[i] + 1));
      else if (i >= 12)
        check($sformatf("%s contig%0d", tag, i), 64'(qa[i].stamp), 64'(qa[i-1].stamp + 1));
    end
  endtask

  task automatic verify_b(input string tag);
    check({tag, " n_out"}, 64'(qb.size()), 64'd12);
    check({tag, " done_cnt"}, 64'(done_cnt_b), 64'd1);
    check({tag, " flush_seen"}, 64'(flush_cnt_b), 64'd0);
    for (int i = 0; i < qb.size() && i < 12; i++) begin
      int c, r;
      c = i % 4;
      r = i / 4;
      check($sformatf("%s pix%0d", tag, i),
            {qb[i].data, qb[i].col, qb[i].row, qb[i].flush, qb[i].done},
            {16'(r * 16 + c), 16'(c), 16'(r), 1'b0, (i == 11)});
    end
  endtask

  initial begin
    bit hit;
    #3;
    check("reset_outs", {ready_a, data_a, col_a, row_a, valid_a, flush_a, busy_a, done_a}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {ready_a, valid_a, busy_a, done_a}, '0);

    // continuous stream, both window sizes
    run_frame(1'b0, -1, -1, 25);
    verify_a("cont");
    verify_b("win1x1");

    // valid_i toggling
    run_frame(1'b1, -1, -1, 25);
    verify_a("toggle");

    // abort after the 6th accept
    run_frame(1'b0, 6, -1, 10);
    check("abort n_out", 64'(qa.size()), 64'd6);
    check("abort done", 64'(done_cnt_a), 64'd0);
    check("abort outs", {ready_a, valid_a, flush_a, busy_a}, '0);
    for (int i = 0; i < qa.size() && i < 6; i++)
      check($sformatf("abort pix%0d", i), {qa[i].col, qa[i].row},
            {16'(i % 4), 16'(i / 4)});
    run_frame(1'b0, -1, -1, 25);
    verify_a("restart");

    // asynchronous reset in the middle of FLUSH
    run_frame(1'b0, -1, -1, 0);
    hit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (flush_a) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_flush_reached", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outs",
             {ready_a, data_a, col_a, row_a, valid_a, flush_a, busy_a, done_a}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {ready_a, valid_a, busy_a}, '0);
    run_frame(1'b0, -1, -1, 25);
    verify_a("after_rst");

    // valid_i held high in IDLE, then a stray start mid-stream
    qa.delete();
    valid_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_valid ready", 64'(ready_a), 64'd0);
    check("idle_valid n_out", 64'(qa.size()), 64'd0);
    valid_i = 1'b0;
    run_frame(1'b0, -1, 5, 25);
    verify_a("stray_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
